reg_alu_control_sequencer: RTL and testbench
============================================

Name: reg_alu_control_sequencer

Overview:
Hardwired control unit that generates datapath control strobes for instruction fetch and for register-register ALU execution (add/sub/and/or). It replaces the hand-sequenced T0–T5 stimulus: the sequencer decodes the instruction register and drives the bus-source select, register-load and memory strobes cycle by cycle. It is generalised over register count, ALU op width and memory wait states.

Parameters:
DATA_W, 32, instruction/datapath word width
NUM_REGS, 16, general registers; one-hot Rin/Rout width
OPC_W, 5, opcode field width, located at IR[DATA_W-1 -: OPC_W]
REG_W, 4, register-field width; Ra, Rb, Rc are packed directly below the opcode
ALUOP_W, 4, width of the ALU operation select

Ports:
Clock  in  1  rising-edge clock
Resetn  in  1  asynchronous active-low reset
Run  in  1  level; 1 = fetch/execute, 0 = stop at the next T0 boundary
IR  in  DATA_W  current instruction register contents
MemReady  in  1  memory read data valid on MDR input this cycle
PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, MDRin, MDRout, IRin, Yin  out  1 each  datapath strobes
Rout  out  NUM_REGS  one-hot register bus-source select
Rin  out  NUM_REGS  one-hot register load enable
AluOp  out  ALUOP_W  ALU operation: ADD=1, SUB=2, AND=3, OR=4, NONE=0
Done  out  1  one-cycle pulse when an instruction retires
Illegal  out  1  one-cycle pulse on an unsupported opcode
Halted  out  1  level; set in HALT

Behaviour:
- All outputs are registered Moore decodes of state. Reset value: every output is 0, and the state is IDLE.
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT.
- IDLE: if Run=1, go to T0.
- T0: assert PCout, MARin, IncPC, Zin, AluOp=ADD. Next state is T1.
- T1: assert ZLOout, PCin, Read, MDRin.
  - PCin is asserted only in the first T1 cycle.
  - Remain in T1 until MemReady=1, holding Read and MDRin; this gives wait states.
  - When MemReady=1, go to T2.
- T2: assert MDRout, IRin. Next state is T3.
- Decode happens on entry to T3, using IR as captured after T2:
  - opc=3 → ADD
  - opc=4 → SUB
  - opc=5 → AND
  - opc=6 → OR
  - opc=27 → HALT
  - anything else → pulse Illegal and return to T0 (or IDLE if Run=0); Done is not asserted.
- Register fields:
  - Ra = IR[DATA_W-OPC_W-1 -: REG_W]
  - Rb = the next REG_W bits below Ra
  - Rc = the next REG_W bits below Rb
- Out-of-range register index: if an index is ≥ NUM_REGS, the one-hot select is all-zero and Illegal pulses at T3.
- T3: Rout[Rb]=1, Yin=1.
- T4: Rout[Rc]=1, Zin=1, AluOp=decoded op.
- T5: ZLOout=1, Rin[Ra]=1, Done=1. Next state is T0 if Run=1, else IDLE.
- HALT: Halted=1. Only reset exits HALT; Run is ignored.
- Run dropping mid-instruction: the current instruction completes through T5.
- Rout and Rin are never both non-zero in the same cycle.
- At most one bus-source strobe is active per cycle (PCout, ZLOout, MDRout, Rout).
- Asynchronous reset at any state forces IDLE and all outputs to 0 immediately.
- Latency: 6 cycles per instruction with zero wait states, plus one cycle per MemReady=0 cycle in T1.

Optional Feature:
STEP_EN:
- With the macro defined: add input Step (1 bit). Every state transition additionally requires Step=1 in the current cycle; otherwise the state and its outputs hold. Done and Illegal still pulse only once.
- Without the macro: no Step port; transitions occur every cycle, as described above.

Decomposition:
- Package ctrl_pkg holds:
  - the state enumeration constants
  - the opcode constants (ADD=3, SUB=4, AND=5, OR=6, HALT=27)
  - the AluOp encodings
- Sub-module onehot_decoder (parameter N=NUM_REGS) is instantiated twice, for Rin and Rout. Its output is all-zero when the enable is low or the index is ≥ N.

Test Plan:
- Reset, then Run=1, MemReady tied to 1, IR=0x18918000 (add R1,R2,R3):
  - T0..T5 occur in 6 consecutive cycles.
  - Rout=0x0004 at T3, Rout=0x0008 at T4 with AluOp=1, Rin=0x0002 with Done=1 at T5.
- Same fetch with MemReady low for 3 cycles:
  - T1 lasts 4 cycles, with Read and MDRin high throughout.
  - PCin is high only in the first T1 cycle.
- IR opcode 5'd9:
  - Illegal pulses for one cycle after T2; the next cycle is T0.
  - Rin stays 0 and Done is not asserted.
- IR opcode 27:
  - Halted=1 after T2, and stays 1 with Run toggling for 20 cycles.
  - Resetn=0 clears Halted.
- Run deasserted during T4:
  - T5 completes with Done=1, then the sequencer enters IDLE with all strobes 0.
  - Reasserting Run restarts at T0.
- Resetn asserted in T4 (async, mid-cycle):
  - Zin, Rout and AluOp clear immediately, before the next clock edge.
  - The sequencer returns to IDLE.

Source files
------------

// File: rtl/reg_alu_control_sequencer_pkg.sv
// rtl/reg_alu_control_sequencer_pkg.sv - states, opcodes, ALU encodings and strobe bundle for the sequencer
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
    } state_t;

    localparam int OPC_ADD  = 3;
    localparam int OPC_SUB  = 4;
    localparam int OPC_AND  = 5;
    localparam int OPC_OR   = 6;
    localparam int OPC_HALT = 27;

    localparam int ALU_NONE = 0;
    localparam int ALU_ADD  = 1;
    localparam int ALU_SUB  = 2;
    localparam int ALU_AND  = 3;
    localparam int ALU_OR   = 4;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic z_in;
        logic zlo_out;
        logic pc_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic done;
        logic illegal;
        logic halted;
    } strobes_t;

    // ALU_NONE doubles as the "not a register-register op" marker
    function automatic int alu_of_opc(input int opc);
        case (opc)
            OPC_ADD: return ALU_ADD;
            OPC_SUB: return ALU_SUB;
            OPC_AND: return ALU_AND;
            OPC_OR:  return ALU_OR;
            default: return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/reg_alu_control_sequencer_if.sv
// rtl/reg_alu_control_sequencer_if.sv - sequencer-to-datapath control interface (optional Step under STEP_EN)
interface reg_alu_control_sequencer_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ALUOP_W  = 4
);
    logic                Run;
    logic [DATA_W-1:0]   IR;
    logic                MemReady;
`ifdef STEP_EN
    logic                Step;
`endif
    logic                PCout, MARin, IncPC, Zin, ZLOout, PCin;
    logic                Read, MDRin, MDRout, IRin, Yin;
    logic [NUM_REGS-1:0] Rout;
    logic [NUM_REGS-1:0] Rin;
    logic [ALUOP_W-1:0]  AluOp;
    logic                Done, Illegal, Halted;

    modport master (
        input  Run, IR, MemReady,
`ifdef STEP_EN
        input  Step,
`endif
        output PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, MDRin, MDRout, IRin, Yin,
        output Rout, Rin, AluOp, Done, Illegal, Halted
    );

    modport slave (
        output Run, IR, MemReady,
`ifdef STEP_EN
        output Step,
`endif
        input  PCout, MARin, IncPC, Zin, ZLOout, PCin, Read, MDRin, MDRout, IRin, Yin,
        input  Rout, Rin, AluOp, Done, Illegal, Halted
    );
endinterface

// File: rtl/reg_alu_control_sequencer_onehot_decoder.sv
// rtl/reg_alu_control_sequencer_onehot_decoder.sv - index to one-hot select, zero when disabled or out of range
module onehot_decoder #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         en_i,
    input  logic [W-1:0] idx_i,
    output logic [N-1:0] onehot_o
);
    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < N; i++) begin
            if (en_i && (32'(idx_i) == $unsigned(i))) onehot_o[i] = 1'b1;
        end
    end
endmodule

// File: rtl/reg_alu_control_sequencer.sv
// rtl/reg_alu_control_sequencer.sv - hardwired fetch/ALU-execute control sequencer; STEP_EN adds single-step gating
module reg_alu_control_sequencer
    import ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int OPC_W    = 5,
    parameter int REG_W    = 4,
    parameter int ALUOP_W  = 4
) (
    input logic                     Clock,
    input logic                     Resetn,
    reg_alu_control_sequencer_if.master bus
);
    state_t              state_q, state_d;
    strobes_t            str_q, str_d;
    logic [ALUOP_W-1:0]  aluop_q, aluop_d, op_q, op_d, dec_op;
    logic [REG_W-1:0]    ra_q, ra_d, rc_q, rc_d, rout_idx;
    logic                bad_q, bad_d, bad_now, is_halt, adv;
    logic                rout_en, rin_en;
    logic [NUM_REGS-1:0] rout_q, rout_d, rin_q, rin_d, rout_dec, rin_dec;
    logic [OPC_W-1:0]    opc;
    logic [REG_W-1:0]    ra_f, rb_f, rc_f;
    logic                unused_ir;

    assign opc  = bus.IR[DATA_W-1 -: OPC_W];
    assign ra_f = bus.IR[DATA_W-OPC_W-1 -: REG_W];
    assign rb_f = bus.IR[DATA_W-OPC_W-REG_W-1 -: REG_W];
    assign rc_f = bus.IR[DATA_W-OPC_W-2*REG_W-1 -: REG_W];
    assign unused_ir = ^bus.IR[DATA_W-OPC_W-3*REG_W-1:0];

    assign dec_op  = ALUOP_W'(alu_of_opc(int'(opc)));
    assign is_halt = (int'(opc) == OPC_HALT);
    assign bad_now = (dec_op == '0) || (int'(ra_f) >= NUM_REGS)
                  || (int'(rb_f) >= NUM_REGS) || (int'(rc_f) >= NUM_REGS);

`ifdef STEP_EN
    assign adv = bus.Step;
`else
    assign adv = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.Run) state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    if (bus.MemReady) state_d = S_T2;
            S_T2:    state_d = is_halt ? S_HALT : S_T3;
            S_T3:    state_d = bad_q ? (bus.Run ? S_T0 : S_IDLE) : S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = bus.Run ? S_T0 : S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        if (!adv) state_d = state_q;
    end

    // The instruction is decoded as it leaves T2; IR must be valid by that edge
    always_comb begin
        op_d  = op_q;
        ra_d  = ra_q;
        rc_d  = rc_q;
        bad_d = bad_q;
        if (state_q == S_T2 && state_d == S_T3) begin
            op_d  = dec_op;
            ra_d  = ra_f;
            rc_d  = rc_f;
            bad_d = bad_now;
        end
    end

    // Outputs are decoded from the next state so the registered strobes line up with state_q
    always_comb begin
        str_d    = '0;
        aluop_d  = '0;
        rout_en  = 1'b0;
        rout_idx = rc_q;
        rin_en   = 1'b0;
        case (state_d)
            S_T0: begin
                str_d.pc_out = 1'b1;
                str_d.mar_in = 1'b1;
                str_d.inc_pc = 1'b1;
                str_d.z_in   = 1'b1;
                aluop_d      = ALUOP_W'(ALU_ADD);
            end
            S_T1: begin
                str_d.zlo_out = 1'b1;
                str_d.read    = 1'b1;
                str_d.mdr_in  = 1'b1;
                str_d.pc_in   = (state_q != S_T1);
            end
            S_T2: begin
                str_d.mdr_out = 1'b1;
                str_d.ir_in   = 1'b1;
            end
            S_T3: begin
                if (bad_now) begin
                    str_d.illegal = 1'b1;
                end else begin
                    str_d.y_in = 1'b1;
                    rout_en    = 1'b1;
                    rout_idx   = rb_f;
                end
            end
            S_T4: begin
                str_d.z_in = 1'b1;
                aluop_d    = op_q;
                rout_en    = 1'b1;
            end
            S_T5: begin
                str_d.zlo_out = 1'b1;
                str_d.done    = 1'b1;
                rin_en        = 1'b1;
            end
            S_HALT:  str_d.halted = 1'b1;
            default: ;
        endcase
        if (!adv) begin
            str_d         = str_q;
            str_d.done    = 1'b0;
            str_d.illegal = 1'b0;
            aluop_d       = aluop_q;
        end
    end

    onehot_decoder #(.N(NUM_REGS), .W(REG_W)) u_rout_dec (
        .en_i(rout_en), .idx_i(rout_idx), .onehot_o(rout_dec)
    );
    onehot_decoder #(.N(NUM_REGS), .W(REG_W)) u_rin_dec (
        .en_i(rin_en), .idx_i(ra_q), .onehot_o(rin_dec)
    );

    assign rout_d = adv ? rout_dec : rout_q;
    assign rin_d  = adv ? rin_dec  : rin_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            str_q   <= '0;
            aluop_q <= '0;
            op_q    <= '0;
            ra_q    <= '0;
            rc_q    <= '0;
            bad_q   <= 1'b0;
            rout_q  <= '0;
            rin_q   <= '0;
        end else begin
            state_q <= state_d;
            str_q   <= str_d;
            aluop_q <= aluop_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rc_q    <= rc_d;
            bad_q   <= bad_d;
            rout_q  <= rout_d;
            rin_q   <= rin_d;
        end
    end

    assign bus.PCout   = str_q.pc_out;
    assign bus.MARin   = str_q.mar_in;
    assign bus.IncPC   = str_q.inc_pc;
    assign bus.Zin     = str_q.z_in;
    assign bus.ZLOout  = str_q.zlo_out;
    assign bus.PCin    = str_q.pc_in;
    assign bus.Read    = str_q.read;
    assign bus.MDRin   = str_q.mdr_in;
    assign bus.MDRout  = str_q.mdr_out;
    assign bus.IRin    = str_q.ir_in;
    assign bus.Yin     = str_q.y_in;
    assign bus.Done    = str_q.done;
    assign bus.Illegal = str_q.illegal;
    assign bus.Halted  = str_q.halted;
    assign bus.Rout    = rout_q;
    assign bus.Rin     = rin_q;
    assign bus.AluOp   = aluop_q;

endmodule

// File: tb/tb_reg_alu_control_sequencer.sv
// tb/tb_reg_alu_control_sequencer.sv - directed self-checking bench for reg_alu_control_sequencer
module tb_reg_alu_control_sequencer;

    // strobe vector order: PCout MARin IncPC Zin ZLOout PCin Read MDRin MDRout IRin Yin Done Illegal Halted
    localparam logic [13:0] ST_IDLE = 14'h0000;
    localparam logic [13:0] ST_T0   = 14'h3C00;
    localparam logic [13:0] ST_T1F  = 14'h03C0;
    localparam logic [13:0] ST_T1W  = 14'h02C0;
    localparam logic [13:0] ST_T2   = 14'h0030;
    localparam logic [13:0] ST_T3   = 14'h0008;
    localparam logic [13:0] ST_T4   = 14'h0400;
    localparam logic [13:0] ST_T5   = 14'h0204;
    localparam logic [13:0] ST_ILL  = 14'h0002;
    localparam logic [13:0] ST_HLT  = 14'h0001;

    localparam logic [31:0] IR_ADD  = 32'h1891_8000;
    localparam logic [31:0] IR_ILL  = 32'h4800_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;

    logic        Clock;
    logic        Resetn;
    logic [13:0] strobes;
    int          tests_run;
    int          tests_failed;

    reg_alu_control_sequencer_if #(.DATA_W(32), .NUM_REGS(16), .ALUOP_W(4)) bus ();

    reg_alu_control_sequencer #(
        .DATA_W(32), .NUM_REGS(16), .OPC_W(5), .REG_W(4), .ALUOP_W(4)
    ) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .bus   (bus)
    );

    assign strobes = {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.ZLOout, bus.PCin,
                      bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin,
                      bus.Done, bus.Illegal, bus.Halted};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [13:0] e_str,
                        input logic [15:0] e_rout, input logic [15:0] e_rin,
                        input logic [3:0] e_op);
        logic excl;
        @(negedge Clock);
        check({tag, ".strobes"}, 32'(strobes), 32'(e_str));
        check({tag, ".rout"},    32'(bus.Rout), 32'(e_rout));
        check({tag, ".rin"},     32'(bus.Rin), 32'(e_rin));
        check({tag, ".aluop"},   32'(bus.AluOp), 32'(e_op));
        excl = ($countones({bus.PCout, bus.ZLOout, bus.MDRout, |bus.Rout}) <= 1)
            && !((|bus.Rout) && (|bus.Rin));
        check({tag, ".bus_excl"}, 32'(excl), 32'd1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Resetn       = 1'b0;
        bus.Run      = 1'b0;
        bus.MemReady = 1'b1;
        bus.IR       = '0;
`ifdef STEP_EN
        bus.Step     = 1'b1;
`endif
        @(negedge Clock);
        step("reset", ST_IDLE, 16'h0, 16'h0, 4'd0);
        Resetn  = 1'b1;
        bus.Run = 1'b1;
        bus.IR  = IR_ADD;

        // add R1,R2,R3 with zero wait states
        step("add.t0", ST_T0,  16'h0,    16'h0,    4'd1);
        step("add.t1", ST_T1F, 16'h0,    16'h0,    4'd0);
        step("add.t2", ST_T2,  16'h0,    16'h0,    4'd0);
        step("add.t3", ST_T3,  16'h0004, 16'h0,    4'd0);
        step("add.t4", ST_T4,  16'h0008, 16'h0,    4'd1);
        step("add.t5", ST_T5,  16'h0,    16'h0002, 4'd0);

        // three memory wait states in T1
        step("wait.t0", ST_T0, 16'h0, 16'h0, 4'd1);
        bus.MemReady = 1'b0;
        step("wait.t1a", ST_T1F, 16'h0, 16'h0, 4'd0);
        step("wait.t1b", ST_T1W, 16'h0, 16'h0, 4'd0);
        step("wait.t1c", ST_T1W, 16'h0, 16'h0, 4'd0);
        step("wait.t1d", ST_T1W, 16'h0, 16'h0, 4'd0);
        bus.MemReady = 1'b1;
        step("wait.t2", ST_T2, 16'h0,    16'h0,    4'd0);
        step("wait.t3", ST_T3, 16'h0004, 16'h0,    4'd0);
        step("wait.t4", ST_T4, 16'h0008, 16'h0,    4'd1);
        step("wait.t5", ST_T5, 16'h0,    16'h0002, 4'd0);
        bus.IR = IR_ILL;

        // opcode 9 is illegal: one Illegal cycle, then straight back to T0
        step("ill.t0",  ST_T0,  16'h0, 16'h0, 4'd1);
        step("ill.t1",  ST_T1F, 16'h0, 16'h0, 4'd0);
        step("ill.t2",  ST_T2,  16'h0, 16'h0, 4'd0);
        step("ill.t3",  ST_ILL, 16'h0, 16'h0, 4'd0);
        step("ill.nxt", ST_T0,  16'h0, 16'h0, 4'd1);
        bus.IR = IR_ADD;

        // Run dropped in T4: instruction retires, then IDLE until Run returns
        step("stop.t1", ST_T1F, 16'h0,    16'h0,    4'd0);
        step("stop.t2", ST_T2,  16'h0,    16'h0,    4'd0);
        step("stop.t3", ST_T3,  16'h0004, 16'h0,    4'd0);
        step("stop.t4", ST_T4,  16'h0008, 16'h0,    4'd1);
        bus.Run = 1'b0;
        step("stop.t5",    ST_T5,   16'h0, 16'h0002, 4'd0);
        step("stop.idle1", ST_IDLE, 16'h0, 16'h0,    4'd0);
        step("stop.idle2", ST_IDLE, 16'h0, 16'h0,    4'd0);
        bus.Run = 1'b1;
        step("restart.t0", ST_T0, 16'h0, 16'h0, 4'd1);

        // asynchronous reset landing in the middle of T4
        step("arst.t1", ST_T1F, 16'h0,    16'h0, 4'd0);
        step("arst.t2", ST_T2,  16'h0,    16'h0, 4'd0);
        step("arst.t3", ST_T3,  16'h0004, 16'h0, 4'd0);
        step("arst.t4", ST_T4,  16'h0008, 16'h0, 4'd1);
        #2 Resetn = 1'b0;
        #1;
        check("arst.zin",   32'(bus.Zin),   32'd0);
        check("arst.rout",  32'(bus.Rout),  32'd0);
        check("arst.aluop", 32'(bus.AluOp), 32'd0);
        bus.Run = 1'b0;
        step("arst.hold", ST_IDLE, 16'h0, 16'h0, 4'd0);
        Resetn = 1'b1;
        step("arst.idle", ST_IDLE, 16'h0, 16'h0, 4'd0);
        bus.Run = 1'b1;
        step("arst.t0", ST_T0, 16'h0, 16'h0, 4'd1);
        bus.IR = IR_HALT;

        // HALT is sticky regardless of Run; only reset leaves it
        step("halt.t1", ST_T1F, 16'h0, 16'h0, 4'd0);
        step("halt.t2", ST_T2,  16'h0, 16'h0, 4'd0);
        step("halt.in", ST_HLT, 16'h0, 16'h0, 4'd0);
        for (int i = 0; i < 20; i++) begin
            bus.Run = ~bus.Run;
            step("halt.hold", ST_HLT, 16'h0, 16'h0, 4'd0);
        end
        #2 Resetn = 1'b0;
        #1;
        check("halt.reset", 32'(bus.Halted), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
